wb_spi_slave: RTL and testbench
===============================

// Module: wb_spi_slave
// PURPOSE
//  SPI target (mode 0, MSB first) with a Wishbone slave register port on the conbus.
//  It is the responder end of the SoC SPI link: an external SPI master drives
//  sck, cs_n and mosi; LM32 firmware reads received bytes and queues reply bytes.
//  Single-byte RX and TX buffers carry sticky overrun/underrun flags and a level IRQ.
// PARAMETERS
//  SYNC_STAGES   2     flops per synchronizer on spi_sck_i/spi_cs_n_i/spi_mosi_i (>=2)
//  IDLE_BYTE     8'hFF byte shifted out when no TX data is queued (underrun)
// PORTS
//  clk          in   1   system clock; all logic on rising edge
//  rst          in   1   synchronous reset, active-low (rst==0 resets on next clk edge)
//  wb_adr_i     in   32  Wishbone address; only [3:2] decoded
//  wb_dat_i     in   32  write data
//  wb_dat_o     out  32  read data, registered
//  wb_sel_i     in   4   byte selects; only [0] gates register writes
//  wb_we_i      in   1   write enable
//  wb_cyc_i     in   1   bus cycle
//  wb_stb_i     in   1   strobe
//  wb_ack_o     out  1   one-cycle acknowledge
//  spi_sck_i    in   1   SPI clock from master, asynchronous
//  spi_cs_n_i   in   1   chip select, active-low, asynchronous
//  spi_mosi_i   in   1   master-out data, asynchronous
//  spi_miso_o   out  1   slave-out data
//  spi_miso_oe  out  1   MISO output enable (1 while cs active)
//  intr         out  1   level interrupt, active-high
// BEHAVIOUR
//  Reset: wb_ack_o=0, wb_dat_o=0, spi_miso_o=1, spi_miso_oe=0, intr=0; all flags/buffers/ctrl=0.
//  WB: ack=1 the cycle after cyc&stb&~ack; exactly one cycle; no wait states; no err/rty.
//  Register map (adr[3:2]):
//   0x0 RXDATA  R: [7:0]=rx_buf; a read (on ack cycle) clears rx_valid. W: ignored.
//   0x4 TXDATA  W (sel[0]): tx_buf<=dat[7:0], tx_full<=1; overwrites if already full. R: 0.
//   0x8 STATUS  R: b0 rx_valid, b1 tx_full, b2 rx_ovr, b3 tx_udr, b4 busy(cs active).
//               W (sel[0]): write-1-to-clear b2,b3; other bits ignored.
//   0xC CTRL    R/W (sel[0]): b0 rx_ie, b1 tx_ie. Unused bits read 0.
//  intr = (rx_valid & rx_ie) | (~tx_full & tx_ie), registered (1 cycle after cause).
//  SPI front end: 2-FF (SYNC_STAGES) sync on all three inputs, then edge detect on sck/cs_n.
//   spi_sck_i must be <= clk/8; CPOL=0, CPHA=0 only.
//  FSM: IDLE (cs_n_s=1) -> ACTIVE on cs_n_s falling edge; ACTIVE -> IDLE on cs_n_s rising.
//   IDLE->ACTIVE: bitcnt<=0; shift_tx<=tx_full?tx_buf:IDLE_BYTE; tx_full<=0;
//     tx_udr<=1 if it was empty. miso_oe=1 and miso_o=shift_tx[7] while ACTIVE.
//   sck rise (ACTIVE): shift_rx<={shift_rx[6:0],mosi_s}; bitcnt<=bitcnt+1 (3-bit, wraps).
//     On bitcnt==7: rx_buf<={shift_rx[6:0],mosi_s}, rx_valid<=1;
//     rx_ovr<=1 if rx_valid already 1 (new byte overwrites old).
//   sck fall (ACTIVE): bitcnt!=0 -> shift_tx<<1; bitcnt==0 (byte done) -> reload as at
//     cs start (tx_buf or IDLE_BYTE + tx_udr).
//   ACTIVE->IDLE mid-byte: partial byte discarded, no rx_valid, bitcnt<=0, miso_oe<=0.
//   sck edges while IDLE are ignored.
//  Latency: rx_valid visible SYNC_STAGES+2 clk after the 8th sck rising edge at the pin.
//  Simultaneous events:
//   RXDATA read + byte completion in the same cycle: new byte wins; rx_valid stays 1; no ovr.
//   TXDATA write + reload in the same cycle: reload takes the OLD buffer state
//     (old byte, or IDLE_BYTE + udr); the new byte lands in tx_buf and tx_full=1.
//   W1C of rx_ovr/tx_udr + new set in the same cycle: set wins.
//  rst low mid-transfer: everything returns to reset values; the FSM re-enters ACTIVE only
//   on a fresh cs_n falling edge after rst releases.
// STRUCTURE
//  Shared include spi_defs.vh: register offsets (RXDATA/TXDATA/STATUS/CTRL),
//   STATUS/CTRL bit positions, IDLE_BYTE default. Same file is used by the firmware header generator.
//  Sub-module spi_slave_sync: N-stage synchronizer + rise/fall pulse outputs, instantiated 3x.
//  Top level holds the WB decode, buffers/flags, FSM, shifters and the intr register.
// TESTING
//  1 TXDATA=0xA5; master sends 0x3C with cs -> miso returns 0xA5; RXDATA=0x3C; rx_valid 1->0 after read.
//  2 No TXDATA write; one byte transfer -> miso 0xFF; STATUS.b3=1; write STATUS=0x8 -> b3=0.
//  3 Two bytes 0x11,0x22 without reading -> RXDATA=0x22; STATUS.b2=1; rx_valid=1.
//  4 cs_n rises after 5 bits -> rx_valid stays 0; next full byte 0x5A is received correctly.
//  5 CTRL=0x3, TX empty -> intr=1; TXDATA write -> intr=0; byte received -> intr=1 until RXDATA read.
//  6 rst=0 mid-byte -> all outputs at reset values next cycle; the 0x77 sent after release is received intact.

Source files
------------

// File: rtl/wb_spi_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_spi_slave_pkg
//  Brief    : Shared definitions for the Wishbone SPI target: register
//             offsets, STATUS/CTRL bit positions, FSM states, idle byte.
//  Revision : 1.0  initial release
// ============================================================================
package wb_spi_slave_pkg;

    // Two-state transfer FSM: waiting for chip select, or inside a frame
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_t;

    // Register index as decoded from wb_adr_i[3:2]
    localparam logic [1:0] c_reg_rxdata = 2'd0;
    localparam logic [1:0] c_reg_txdata = 2'd1;
    localparam logic [1:0] c_reg_status = 2'd2;
    localparam logic [1:0] c_reg_ctrl   = 2'd3;

    // STATUS bit positions
    localparam int c_st_rx_valid = 0;
    localparam int c_st_tx_full  = 1;
    localparam int c_st_rx_ovr   = 2;
    localparam int c_st_tx_udr   = 3;
    localparam int c_st_busy     = 4;

    // CTRL bit positions
    localparam int c_ctrl_rx_ie = 0;
    localparam int c_ctrl_tx_ie = 1;

    // Byte shifted out on MISO when firmware has not queued anything
    localparam logic [7:0] c_idle_byte_default = 8'hFF;

    // Assemble the STATUS read word from the individual flags
    function automatic logic [31:0] pack_status(input logic rx_valid,
                                                input logic tx_full,
                                                input logic rx_ovr,
                                                input logic tx_udr,
                                                input logic busy);
        logic [31:0] word;
        word                = '0;
        word[c_st_rx_valid] = rx_valid;
        word[c_st_tx_full]  = tx_full;
        word[c_st_rx_ovr]   = rx_ovr;
        word[c_st_tx_udr]   = tx_udr;
        word[c_st_busy]     = busy;
        return word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_spi_slave_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_spi_slave_if
//  Brief    : Wishbone classic slave-port bundle for the SPI target.
//  Revision : 1.0  initial release
// ============================================================================
interface wb_spi_slave_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_spi_slave_sync.sv
`default_nettype none
// ============================================================================
//  Module   : wb_spi_slave_sync
//  Brief    : N-stage synchronizer for an asynchronous SPI pin with
//             single-cycle rise/fall pulses on the synchronized level.
//             Edge pulses stay quiet until the chain has refilled after
//             reset, so a pin already low at release is not seen as a fall.
//  Revision : 1.0  initial release
// ============================================================================
module wb_spi_slave_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic d,
    output logic      q,
    output logic      rise,
    output logic      fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic [STAGES:0]   r_vld;
    logic              w_armed;

    // Synchronizer chain, previous-sample register and fill tracker
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
            r_vld  <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
            r_prev <= r_sync[STAGES-1];
            r_vld  <= {r_vld[STAGES-1:0], 1'b1};
        end
    end

    assign w_armed = r_vld[STAGES];
    assign q       = r_sync[STAGES-1];
    assign rise    = w_armed &  r_sync[STAGES-1] & ~r_prev;
    assign fall    = w_armed & ~r_sync[STAGES-1] &  r_prev;

endmodule
`default_nettype wire

// File: rtl/wb_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : wb_spi_slave
//  Brief    : SPI target (mode 0, MSB first) with a Wishbone register port.
//             Single-byte RX/TX buffers, sticky overrun/underrun flags and a
//             registered level interrupt.
//  Revision : 1.0  initial release
// ============================================================================
module wb_spi_slave
    import wb_spi_slave_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = c_idle_byte_default
) (
    input  wire logic      clk,
    input  wire logic      rst,
    wb_spi_slave_if.slave  wb,
    input  wire logic      spi_sck_i,
    input  wire logic      spi_cs_n_i,
    input  wire logic      spi_mosi_i,
    output logic           spi_miso_o,
    output logic           spi_miso_oe,
    output logic           intr
);

    // ---------------- SPI front end ----------------
    logic w_sck_s, w_sck_rise, w_sck_fall;
    logic w_cs_n_s, w_cs_rise, w_cs_fall;
    logic w_mosi_s, w_mosi_rise, w_mosi_fall;

    wb_spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst(rst), .d(spi_sck_i),
        .q(w_sck_s), .rise(w_sck_rise), .fall(w_sck_fall)
    );

    wb_spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d(spi_cs_n_i),
        .q(w_cs_n_s), .rise(w_cs_rise), .fall(w_cs_fall)
    );

    wb_spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(spi_mosi_i),
        .q(w_mosi_s), .rise(w_mosi_rise), .fall(w_mosi_fall)
    );

    // ---------------- state ----------------
    spi_state_t r_state, w_state_nxt;

    logic [2:0]  r_bitcnt;
    logic [7:0]  r_shift_rx;
    logic [7:0]  r_shift_tx;
    logic [7:0]  r_rx_buf;
    logic [7:0]  r_tx_buf;
    logic        r_rx_valid;
    logic        r_tx_full;
    logic        r_rx_ovr;
    logic        r_tx_udr;
    logic [1:0]  r_ctrl;
    logic        r_ack;
    logic [31:0] r_dat_o;
    logic        r_intr;

    logic w_active, w_start, w_stop, w_bit_rise, w_bit_fall;
    logic w_byte_done, w_reload;

    // ---------------- Wishbone decode ----------------
    logic        w_req, w_acc, w_rd_rx, w_wr;
    logic        w_wr_tx, w_wr_st, w_wr_ctrl;
    logic [1:0]  w_reg;
    logic [31:0] w_rd_mux;

    assign w_reg     = wb.wb_adr_i[3:2];
    assign w_req     = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
    // Side effects happen on the acknowledge cycle
    assign w_acc     = wb.wb_cyc_i & wb.wb_stb_i & r_ack;
    assign w_rd_rx   = w_acc & ~wb.wb_we_i & (w_reg == c_reg_rxdata);
    assign w_wr      = w_acc & wb.wb_we_i & wb.wb_sel_i[0];
    assign w_wr_tx   = w_wr & (w_reg == c_reg_txdata);
    assign w_wr_st   = w_wr & (w_reg == c_reg_status);
    assign w_wr_ctrl = w_wr & (w_reg == c_reg_ctrl);

    // State register for the frame FSM
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle shift/reload strobes
    always_comb begin
        w_state_nxt = r_state;
        w_active    = 1'b0;
        w_start     = 1'b0;
        w_stop      = 1'b0;
        w_bit_rise  = 1'b0;
        w_bit_fall  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = ST_ACTIVE;
                    w_start     = 1'b1;
                end
            end
            ST_ACTIVE: begin
                w_active = 1'b1;
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_stop      = 1'b1;
                end else begin
                    w_bit_rise = w_sck_rise;
                    w_bit_fall = w_sck_fall;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_byte_done = w_bit_rise & (r_bitcnt == 3'd7);
        w_reload    = w_start | (w_bit_fall & (r_bitcnt == 3'd0));
    end

    // Receive side: bit counter, input shifter, RX buffer and its flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bitcnt   <= 3'd0;
            r_shift_rx <= 8'd0;
            r_rx_buf   <= 8'd0;
            r_rx_valid <= 1'b0;
            r_rx_ovr   <= 1'b0;
        end else begin
            if (w_start || w_stop) begin
                r_bitcnt <= 3'd0;
            end else if (w_bit_rise) begin
                r_bitcnt <= r_bitcnt + 3'd1;
            end
            if (w_bit_rise) begin
                r_shift_rx <= {r_shift_rx[6:0], w_mosi_s};
            end
            if (w_byte_done) begin
                r_rx_buf <= {r_shift_rx[6:0], w_mosi_s};
            end
            // A byte landing in the same cycle as a read keeps rx_valid set
            if (w_byte_done) begin
                r_rx_valid <= 1'b1;
            end else if (w_rd_rx) begin
                r_rx_valid <= 1'b0;
            end
            if (w_byte_done && r_rx_valid && !w_rd_rx) begin
                r_rx_ovr <= 1'b1;
            end else if (w_wr_st && wb.wb_dat_i[c_st_rx_ovr]) begin
                r_rx_ovr <= 1'b0;
            end
        end
    end

    // Transmit side: output shifter, TX buffer and its flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shift_tx <= 8'd0;
            r_tx_buf   <= 8'd0;
            r_tx_full  <= 1'b0;
            r_tx_udr   <= 1'b0;
        end else begin
            // Reload sees the buffer as it was before any same-cycle write
            if (w_reload) begin
                r_shift_tx <= r_tx_full ? r_tx_buf : IDLE_BYTE;
            end else if (w_bit_fall) begin
                r_shift_tx <= {r_shift_tx[6:0], 1'b0};
            end
            if (w_wr_tx) begin
                r_tx_buf <= wb.wb_dat_i[7:0];
            end
            if (w_wr_tx) begin
                r_tx_full <= 1'b1;
            end else if (w_reload) begin
                r_tx_full <= 1'b0;
            end
            if (w_reload && !r_tx_full) begin
                r_tx_udr <= 1'b1;
            end else if (w_wr_st && wb.wb_dat_i[c_st_tx_udr]) begin
                r_tx_udr <= 1'b0;
            end
        end
    end

    // Read-data multiplexer
    always_comb begin
        w_rd_mux = 32'd0;
        case (w_reg)
            c_reg_rxdata: w_rd_mux = {24'd0, r_rx_buf};
            c_reg_txdata: w_rd_mux = 32'd0;
            c_reg_status: w_rd_mux = pack_status(r_rx_valid, r_tx_full,
                                                 r_rx_ovr, r_tx_udr, w_active);
            c_reg_ctrl:   w_rd_mux = {30'd0, r_ctrl};
            default:      w_rd_mux = 32'd0;
        endcase
    end

    // Bus handshake, registered read data, control register and interrupt
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ack   <= 1'b0;
            r_dat_o <= 32'd0;
            r_ctrl  <= 2'd0;
            r_intr  <= 1'b0;
        end else begin
            r_ack <= w_req;
            if (w_req) begin
                r_dat_o <= w_rd_mux;
            end
            if (w_wr_ctrl) begin
                r_ctrl <= wb.wb_dat_i[1:0];
            end
            r_intr <= (r_rx_valid & r_ctrl[c_ctrl_rx_ie]) |
                      (~r_tx_full & r_ctrl[c_ctrl_tx_ie]);
        end
    end

    assign wb.wb_ack_o = r_ack;
    assign wb.wb_dat_o = r_dat_o;
    assign intr        = r_intr;
    assign spi_miso_oe = w_active;
    assign spi_miso_o  = w_active ? r_shift_tx[7] : 1'b1;

    // Inputs and synchronizer outputs with no consumer in this design
    logic w_unused_bits;
    assign w_unused_bits = ^{wb.wb_adr_i[31:4], wb.wb_adr_i[1:0],
                             wb.wb_dat_i[31:8], wb.wb_sel_i[3:1],
                             w_sck_s, w_cs_n_s, w_mosi_rise, w_mosi_fall};

endmodule
`default_nettype wire

// File: tb/tb_wb_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_spi_slave
//  Brief    : Self-checking bench for wb_spi_slave. Acts as SPI master and
//             Wishbone master; expectations come from a byte-level model of
//             the buffers and flags.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_spi_slave;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sck = 1'b0;
    logic cs_n = 1'b1;
    logic mosi = 1'b0;
    logic miso, miso_oe, intr;

    always #5 clk = ~clk;

    wb_spi_slave_if bus ();

    wb_spi_slave #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb         (bus),
        .spi_sck_i  (sck),
        .spi_cs_n_i (cs_n),
        .spi_mosi_i (mosi),
        .spi_miso_o (miso),
        .spi_miso_oe(miso_oe),
        .intr       (intr)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic       m_rxv, m_ovr, m_udr, m_txf, m_busy;
    logic [7:0] m_rxbuf, m_txbuf, m_shift;
    logic [1:0] m_ctrl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rxv = 0; m_ovr = 0; m_udr = 0; m_txf = 0; m_busy = 0;
        m_rxbuf = 0; m_txbuf = 0; m_shift = 0; m_ctrl = 0;
    endtask

    // Next outgoing byte: queued TX byte if any, otherwise idle byte + underrun
    task automatic model_load();
        if (m_txf) begin
            m_shift = m_txbuf;
            m_txf   = 0;
        end else begin
            m_shift = 8'hFF;
            m_udr   = 1;
        end
    endtask

    function automatic logic [31:0] exp_status();
        return {27'd0, m_busy, m_udr, m_ovr, m_txf, m_rxv};
    endfunction

    function automatic logic [31:0] exp_intr();
        return {31'd0, (m_rxv & m_ctrl[0]) | (~m_txf & m_ctrl[1])};
    endfunction

    task automatic wb_cycle(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, output logic [31:0] rd);
        int k;
        bus.wb_adr_i = {28'd0, adr};
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        bus.wb_we_i  = we;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        k = 0;
        @(negedge clk);
        while (!bus.wb_ack_o && k < 8) begin
            @(negedge clk);
            k++;
        end
        check("wb_ack", {31'd0, bus.wb_ack_o}, 32'd1);
        rd = bus.wb_dat_o;
        @(negedge clk);
        check("wb_ack_one_cycle", {31'd0, bus.wb_ack_o}, 32'd0);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic wb_write(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] rd;
        wb_cycle(1'b1, adr, dat, sel, rd);
    endtask

    task automatic wb_read(input logic [3:0] adr, output logic [31:0] rd);
        wb_cycle(1'b0, adr, 32'd0, 4'hF, rd);
    endtask

    task automatic tx_write(input logic [7:0] b);
        wb_write(4'h4, {24'hABCDEF, b}, 4'h1);
        m_txf = 1; m_txbuf = b;
    endtask

    task automatic status_w1c(input logic [31:0] v);
        wb_write(4'h8, v, 4'h1);
        if (v[2]) m_ovr = 0;
        if (v[3]) m_udr = 0;
    endtask

    task automatic ctrl_write(input logic [31:0] v);
        wb_write(4'hC, v, 4'h1);
        m_ctrl = v[1:0];
    endtask

    task automatic check_status(input string tag);
        logic [31:0] rd;
        wb_read(4'h8, rd);
        check(tag, rd, exp_status());
    endtask

    task automatic read_rx(input string tag);
        logic [31:0] rd;
        wb_read(4'h0, rd);
        check(tag, rd, {24'd0, m_rxbuf});
        m_rxv = 0;
    endtask

    task automatic check_intr(input string tag);
        repeat (2) @(negedge clk);
        check(tag, {31'd0, intr}, exp_intr());
    endtask

    task automatic spi_half();
        repeat (8) @(negedge clk);
    endtask

    task automatic frame_start();
        cs_n = 1'b0;
        model_load();
        m_busy = 1;
        spi_half();
    endtask

    task automatic frame_end();
        spi_half();
        cs_n = 1'b1;
        mosi = 1'b0;
        m_busy = 0;
        spi_half();
    endtask

    task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'd0;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            spi_half();
            mi[7-i] = miso;
            sck = 1'b1;
            spi_half();
            sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input string tag, input logic [7:0] mo);
        logic [7:0] mi;
        spi_bits(mo, 8, mi);
        check(tag, {24'd0, mi}, {24'd0, m_shift});
        if (m_rxv) m_ovr = 1;
        m_rxv   = 1;
        m_rxbuf = mo;
        model_load();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic [7:0]  mi;
        bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
        bus.wb_we_i = 0; bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
        model_reset();

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ack",  {31'd0, bus.wb_ack_o}, 32'd0);
        check("rst_dat",  bus.wb_dat_o, 32'd0);
        check("rst_miso", {31'd0, miso}, 32'd1);
        check("rst_oe",   {31'd0, miso_oe}, 32'd0);
        check("rst_intr", {31'd0, intr}, 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_status("rst_status");

        // 1: queued byte goes out, received byte read back, rx_valid clears
        tx_write(8'hA5);
        wb_read(4'h4, rd);
        check("txdata_reads_zero", rd, 32'd0);
        check_status("t1_status_txfull");
        frame_start();
        check("t1_oe_active", {31'd0, miso_oe}, 32'd1);
        check_status("t1_status_busy");
        spi_byte("t1_miso", 8'h3C);
        frame_end();
        check_status("t1_status_rxv");
        read_rx("t1_rxdata");
        check_status("t1_status_cleared");

        // 2: underrun sends idle byte; sel[0]=0 write ignored; W1C clears udr
        status_w1c(32'h8);
        wb_write(4'h4, 32'h0000_0055, 4'hE);
        check_status("t2_sel_gate");
        frame_start();
        spi_byte("t2_miso_idle", 8'h96);
        frame_end();
        check_status("t2_status_udr");
        status_w1c(32'h8);
        check_status("t2_status_udr_clr");

        // 3: two bytes without reading -> overrun, last byte kept
        frame_start();
        spi_byte("t3_miso_b0", 8'h11);
        spi_byte("t3_miso_b1", 8'h22);
        frame_end();
        check_status("t3_status_ovr");
        read_rx("t3_rxdata");
        status_w1c(32'hC);
        check_status("t3_status_clr");

        // 4: aborted partial byte discarded, following byte intact
        frame_start();
        spi_bits(8'hC3, 5, mi);
        frame_end();
        check_status("t4_partial");
        frame_start();
        spi_byte("t4_miso", 8'h5A);
        frame_end();
        read_rx("t4_rxdata");

        // 5: interrupt sources
        status_w1c(32'hC);
        ctrl_write(32'hFF);
        wb_read(4'hC, rd);
        check("t5_ctrl_read", rd, 32'd3);
        check_intr("t5_intr_tx_empty");
        tx_write(8'h42);
        check_intr("t5_intr_tx_full");
        frame_start();
        spi_byte("t5_miso", 8'h81);
        frame_end();
        check_intr("t5_intr_rx");
        ctrl_write(32'h1);
        check_intr("t5_intr_rx_only");
        read_rx("t5_rxdata");
        check_intr("t5_intr_after_read");

        // 6: reset in the middle of a byte
        ctrl_write(32'h2);
        check_intr("t6_intr_before_rst");
        frame_start();
        spi_bits(8'hF0, 4, mi);
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_ack",  {31'd0, bus.wb_ack_o}, 32'd0);
        check("t6_rst_dat",  bus.wb_dat_o, 32'd0);
        check("t6_rst_miso", {31'd0, miso}, 32'd1);
        check("t6_rst_oe",   {31'd0, miso_oe}, 32'd0);
        check("t6_rst_intr", {31'd0, intr}, 32'd0);
        cs_n = 1'b1;
        sck  = 1'b0;
        mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (6) @(negedge clk);
        check_status("t6_status_after_rst");
        frame_start();
        spi_byte("t6_miso", 8'h77);
        frame_end();
        read_rx("t6_rxdata");

        // Randomized transfers against the model
        for (int it = 0; it < 6; it++) begin
            ctrl_write($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
            frame_start();
            for (int b = 0; b < int'($urandom_range(1, 2)); b++) begin
                spi_byte("rnd_miso", 8'($urandom));
            end
            frame_end();
            check_status("rnd_status");
            check_intr("rnd_intr");
            if ($urandom_range(0, 1) == 1) read_rx("rnd_rxdata");
            status_w1c(32'($urandom_range(0, 3)) << 2);
            check_status("rnd_status_w1c");
            check_intr("rnd_intr_w1c");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
